// File: rtl/interrupt_controller_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt controller.
package interrupt_pkg;

    // Number of peripheral sources when the parent does not override it.
    localparam int DEFAULT_NUM_SRC = 4;

    // Register offsets inside the three-byte window starting at BASE_ADDR.
    localparam logic [7:0] REG_STATUS_OFS  = 8'd0;
    localparam logic [7:0] REG_MASK_OFS    = 8'd1;
    localparam logic [7:0] REG_PENDING_OFS = 8'd2;

    // Cycles a source latch stays blind after its ack pulse, so the
    // peripheral's registered clear can reach its raise line.
    localparam int         HOLDOFF_WIDTH = 2;
    localparam logic [HOLDOFF_WIDTH-1:0] HOLDOFF_LOAD = 2'd2;

    // Dispatch FSM: IDLE waits for an eligible source, SERVICE holds the
    // processor request until the processor acknowledges it.
    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } dispatchState_e;

    // Index of the lowest set bit; returns 0 for an all-zero vector, which
    // callers never use because dispatch is gated on a non-zero vector.
    function automatic logic [2:0] lowestSetIndex(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Peripheral and processor handshake signals of the interrupt controller,
// together with the bus address and write strobe.
interface interrupt_controller_if
    import interrupt_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC
);

    logic [7:0]         BUS_ADDR;
    logic               BUS_WE;
    logic [NUM_SRC-1:0] SRC_RAISE;
    logic [NUM_SRC-1:0] SRC_ACK;
    logic               CPU_INT_RAISE;
    logic               CPU_INT_ACK;

    // Processor / peripheral side: drives the bus, raise lines and the ack.
    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output SRC_RAISE,
        output CPU_INT_ACK,
        input  SRC_ACK,
        input  CPU_INT_RAISE
    );

    // Controller side.
    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  SRC_RAISE,
        input  CPU_INT_ACK,
        output SRC_ACK,
        output CPU_INT_RAISE
    );

endinterface

// File: rtl/interrupt_controller_source_latch.sv
// One peripheral source: turns a level raise into a pending bit, acks the
// peripheral for one cycle and then ignores the line for a short holdoff.
module irq_source_latch
    import interrupt_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic raise_i,
    input  logic w1c_i,
    input  logic dispatchClr_i,
    output logic pending_o,
    output logic ack_o
);

    logic                     pending_q, pending_d;
    logic                     ack_q, ack_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
    logic                     capture;

    // Capture has priority over both the software clear and the dispatch
    // clear; the holdoff starts counting on the ack pulse itself.
    always_comb begin
        capture   = raise_i && !pending_q && (holdoff_q == '0);
        pending_d = pending_q;
        ack_d     = capture;
        holdoff_d = holdoff_q;
        if (capture) begin
            pending_d = 1'b1;
        end else if (w1c_i || dispatchClr_i) begin
            pending_d = 1'b0;
        end
        if (ack_q) begin
            holdoff_d = HOLDOFF_LOAD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - 1'b1;
        end
    end

    // Latch state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            holdoff_q <= '0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_d;
            holdoff_q <= holdoff_d;
        end
    end

    assign pending_o = pending_q;
    assign ack_o     = ack_q;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: per-source latches, lowest-index
// priority dispatch to the processor, and a three-register bus window.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int         NUM_SRC    = DEFAULT_NUM_SRC,
    parameter logic [7:0] BASE_ADDR  = 8'hE0,
    parameter logic [7:0] RESET_MASK = 8'hFF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    inout  wire  [7:0]           BUS_DATA,
    interrupt_controller_if.slave bus
);

    localparam logic [7:0] ADDR_STATUS  = BASE_ADDR + REG_STATUS_OFS;
    localparam logic [7:0] ADDR_MASK    = BASE_ADDR + REG_MASK_OFS;
    localparam logic [7:0] ADDR_PENDING = BASE_ADDR + REG_PENDING_OFS;
    localparam logic [NUM_SRC-1:0] MASK_INIT = RESET_MASK[NUM_SRC-1:0];

    dispatchState_e     state_q, state_d;
    logic [2:0]         activeId_q, activeId_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               readEn_q, readEn_d;
    logic [7:0]         readData_q, readData_d;

    logic [NUM_SRC-1:0] pendingVec;
    logic [NUM_SRC-1:0] srcAck;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] w1cVec;
    logic [2:0]         lowestIdx;
    logic               dispatchFire;
    logic               wrMask, wrPending, rdHit;
    logic               unusedBusBits;

    // Bits of the write data above NUM_SRC carry no meaning for this block.
    assign unusedBusBits = ^BUS_DATA;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_source_latch u_latch (
            .CLK           (CLK),
            .RESET         (RESET),
            .raise_i       (bus.SRC_RAISE[i]),
            .w1c_i         (w1cVec[i]),
            .dispatchClr_i (dispatchFire && (lowestIdx == 3'(i))),
            .pending_o     (pendingVec[i]),
            .ack_o         (srcAck[i])
        );
    end

    assign bus.SRC_ACK       = srcAck;
    assign bus.CPU_INT_RAISE = (state_q == SERVICE);

    // Address decode for the register window.
    always_comb begin
        wrMask    = bus.BUS_WE && (bus.BUS_ADDR == ADDR_MASK);
        wrPending = bus.BUS_WE && (bus.BUS_ADDR == ADDR_PENDING);
        rdHit     = !bus.BUS_WE && ((bus.BUS_ADDR == ADDR_STATUS) ||
                                    (bus.BUS_ADDR == ADDR_MASK)   ||
                                    (bus.BUS_ADDR == ADDR_PENDING));
    end

    // Dispatch decision: pick the lowest unmasked pending source while idle,
    // return to idle when the processor acknowledges.
    always_comb begin
        eligible     = pendingVec & mask_q;
        lowestIdx    = lowestSetIndex(8'(eligible));
        state_d      = state_q;
        activeId_d   = activeId_q;
        dispatchFire = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    state_d      = SERVICE;
                    activeId_d   = lowestIdx;
                    dispatchFire = 1'b1;
                end
            end
            SERVICE: begin
                if (bus.CPU_INT_ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dispatch FSM and in-service ID registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            activeId_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            activeId_q <= activeId_d;
        end
    end

    // Register writes and read-data capture from the pre-edge register values.
    always_comb begin
        mask_d     = mask_q;
        w1cVec     = '0;
        readEn_d   = rdHit;
        readData_d = 8'h00;
        if (wrMask) begin
            mask_d = BUS_DATA[NUM_SRC-1:0];
        end
        if (wrPending) begin
            w1cVec = BUS_DATA[NUM_SRC-1:0];
        end
        if (bus.BUS_ADDR == ADDR_STATUS) begin
            readData_d = {(state_q == SERVICE), 4'b0000, activeId_q};
        end else if (bus.BUS_ADDR == ADDR_MASK) begin
            readData_d = 8'(mask_q);
        end else if (bus.BUS_ADDR == ADDR_PENDING) begin
            readData_d = 8'(pendingVec);
        end
    end

    // Mask register and the registered read slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mask_q     <= MASK_INIT;
            readEn_q   <= 1'b0;
            readData_q <= 8'h00;
        end else begin
            mask_q     <= mask_d;
            readEn_q   <= readEn_d;
            readData_q <= readData_d;
        end
    end

    assign BUS_DATA = readEn_q ? readData_q : 8'hZZ;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic for interrupt_controller,
// checked every cycle against a cycle-numbered behavioural model.
module tb_interrupt_controller;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'hE0;

    logic       CLK = 1'b0;
    logic       RESET;
    wire  [7:0] busData;
    logic       busDrvEn;
    logic [7:0] busDrvVal;

    int checkCount = 0;
    int failCount  = 0;

    assign busData = busDrvEn ? busDrvVal : 8'hZZ;

    interrupt_controller_if #(.NUM_SRC(N)) ifc ();

    interrupt_controller #(
        .NUM_SRC    (N),
        .BASE_ADDR  (BASE),
        .RESET_MASK (8'hFF)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (busData),
        .bus      (ifc)
    );

    always #5 CLK = ~CLK;

    // Reference model state: sources remember the edge number of their last
    // capture and are blind for the three edges that follow it.
    bit [N-1:0] mPend, mMask, mAck;
    bit         mInSvc;
    bit [2:0]   mId;
    bit         mRdValid;
    bit [7:0]   mRdVal;
    int         mLastCap [N];
    int         edgeNo = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelEdge();
        bit [N-1:0] elig, nextPend, cap;
        bit [7:0]   ofs;
        ofs = ifc.BUS_ADDR - BASE;
        if (RESET) begin
            mPend = '0; mMask = 4'hF; mAck = '0; mInSvc = 1'b0; mId = 3'd0;
            mRdValid = 1'b0; mRdVal = 8'h00;
            for (int i = 0; i < N; i++) mLastCap[i] = -100;
        end else begin
            elig     = mPend & mMask;
            mRdValid = !ifc.BUS_WE && (ofs <= 8'd2);
            case (ofs)
                8'd0:    mRdVal = {mInSvc, 4'b0000, mId};
                8'd1:    mRdVal = 8'(mMask);
                8'd2:    mRdVal = 8'(mPend);
                default: mRdVal = 8'h00;
            endcase
            nextPend = mPend;
            if (!mInSvc && elig != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (elig[i]) begin
                        mId = 3'(i);
                        break;
                    end
                end
                nextPend[mId] = 1'b0;
                mInSvc = 1'b1;
            end else if (mInSvc && ifc.CPU_INT_ACK) begin
                mInSvc = 1'b0;
            end
            if (ifc.BUS_WE && ofs == 8'd2) nextPend &= ~busDrvVal[N-1:0];
            if (ifc.BUS_WE && ofs == 8'd1) mMask = busDrvVal[N-1:0];
            for (int i = 0; i < N; i++) begin
                cap[i] = ifc.SRC_RAISE[i] && !mPend[i] && (edgeNo - mLastCap[i] >= 4);
                if (cap[i]) begin
                    nextPend[i] = 1'b1;
                    mLastCap[i] = edgeNo;
                end
            end
            mPend = nextPend;
            mAck  = cap;
        end
        edgeNo++;
    endtask

    // One clock cycle with whatever inputs are currently driven, then compare.
    task automatic applyStimulus();
        @(posedge CLK);
        modelEdge();
        #1;
        checkOutput("cpuIntRaise", ifc.CPU_INT_RAISE, mInSvc);
        checkOutput("srcAck", ifc.SRC_ACK, mAck);
        if (mRdValid) checkOutput("busRead", busData, mRdVal);
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
        ifc.BUS_ADDR = addr; ifc.BUS_WE = 1'b1; busDrvEn = 1'b1; busDrvVal = data;
        applyStimulus();
        ifc.BUS_ADDR = 8'h00; ifc.BUS_WE = 1'b0; busDrvEn = 1'b0;
    endtask

    task automatic busRead(input logic [7:0] addr, input logic [7:0] expected, input string tag);
        ifc.BUS_ADDR = addr; ifc.BUS_WE = 1'b0;
        applyStimulus();
        checkOutput(tag, busData, expected);
        ifc.BUS_ADDR = 8'h00;
        applyStimulus();
    endtask

    initial begin
        bit         lastWasRead;
        int         op;
        bit [7:0]   ofs;
        RESET = 1'b1; busDrvEn = 1'b0; busDrvVal = 8'h00;
        ifc.BUS_ADDR = 8'h00; ifc.BUS_WE = 1'b0; ifc.SRC_RAISE = '0; ifc.CPU_INT_ACK = 1'b0;

        // Reset state
        applyStimulus();
        RESET = 1'b0;
        checkOutput("rst.raise", ifc.CPU_INT_RAISE, 0);
        checkOutput("rst.ack", ifc.SRC_ACK, 0);
        busRead(BASE + 8'd1, 8'h0F, "rst.mask");

        // Single source
        ifc.SRC_RAISE = 4'b0001;
        applyStimulus();
        checkOutput("single.ackPulse", ifc.SRC_ACK, 4'b0001);
        applyStimulus();
        checkOutput("single.raiseAfter2", ifc.CPU_INT_RAISE, 1);
        checkOutput("single.ackOnce", ifc.SRC_ACK, 4'b0000);
        busRead(BASE, 8'h80, "single.status");
        ifc.SRC_RAISE = 4'b0000;
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;
        checkOutput("single.ackDrops", ifc.CPU_INT_RAISE, 0);
        busRead(BASE, 8'h00, "single.statusIdle");

        // Priority between sources 3 and 1
        ifc.SRC_RAISE = 4'b1010;
        applyStimulus();
        ifc.SRC_RAISE = 4'b0000;
        applyStimulus();
        checkOutput("prio.raise", ifc.CPU_INT_RAISE, 1);
        busRead(BASE, 8'h81, "prio.firstId");
        busRead(BASE + 8'd2, 8'h08, "prio.pending");
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;
        checkOutput("prio.idleGap", ifc.CPU_INT_RAISE, 0);
        applyStimulus();
        checkOutput("prio.second", ifc.CPU_INT_RAISE, 1);
        busRead(BASE, 8'h83, "prio.secondId");
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;

        // Masking
        busWrite(BASE + 8'd1, 8'h0E);
        ifc.SRC_RAISE = 4'b0001;
        applyStimulus();
        checkOutput("mask.ack", ifc.SRC_ACK, 4'b0001);
        ifc.SRC_RAISE = 4'b0000;
        applyStimulus();
        applyStimulus();
        checkOutput("mask.noRaise", ifc.CPU_INT_RAISE, 0);
        busRead(BASE + 8'd2, 8'h01, "mask.pending");
        busWrite(BASE + 8'd1, 8'h0F);
        checkOutput("mask.nextCycle", ifc.CPU_INT_RAISE, 0);
        applyStimulus();
        checkOutput("mask.unmasked", ifc.CPU_INT_RAISE, 1);
        busRead(BASE, 8'h80, "mask.id");
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;

        // W1C racing a capture of the same bit
        busWrite(BASE + 8'd1, 8'h0B);
        ifc.SRC_RAISE = 4'b0100;
        busWrite(BASE + 8'd2, 8'h04);
        ifc.SRC_RAISE = 4'b0000;
        busRead(BASE + 8'd2, 8'h04, "w1c.raceCaptureWins");
        busWrite(BASE + 8'd2, 8'h04);
        busRead(BASE + 8'd2, 8'h00, "w1c.cleared");
        busWrite(BASE + 8'd1, 8'h0F);

        // Holdoff and re-capture with source 1 held high
        ifc.SRC_RAISE = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            applyStimulus();
            checkOutput("hold.ack1", ifc.SRC_ACK[1], (k == 0 || k == 4) ? 1 : 0);
        end
        ifc.SRC_RAISE = 4'b0000;
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;
        applyStimulus();
        checkOutput("hold.redispatch", ifc.CPU_INT_RAISE, 1);
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;
        applyStimulus();

        // Reset in the middle of a service
        ifc.SRC_RAISE = 4'b0111;
        applyStimulus();
        ifc.SRC_RAISE = 4'b0000;
        applyStimulus();
        busRead(BASE + 8'd2, 8'h06, "rstMid.pending");
        RESET = 1'b1;
        applyStimulus();
        RESET = 1'b0;
        checkOutput("rstMid.raise", ifc.CPU_INT_RAISE, 0);
        busRead(BASE + 8'd2, 8'h00, "rstMid.pendingClr");
        busRead(BASE + 8'd1, 8'h0F, "rstMid.mask");
        ifc.CPU_INT_ACK = 1'b1;
        applyStimulus();
        ifc.CPU_INT_ACK = 1'b0;
        checkOutput("rstMid.spuriousAck", ifc.CPU_INT_RAISE, 0);
        busRead(BASE, 8'h00, "rstMid.status");

        // Randomized traffic
        lastWasRead = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(199) == 0);
            if ($urandom_range(3) == 0) ifc.SRC_RAISE = ifc.SRC_RAISE ^ 4'($urandom_range(15));
            ifc.CPU_INT_ACK = ($urandom_range(3) == 0);
            op = $urandom_range(9);
            ifc.BUS_WE = 1'b0; busDrvEn = 1'b0; ifc.BUS_ADDR = 8'h00;
            if (op <= 3) begin
                ifc.BUS_ADDR = BASE + 8'($urandom_range(3));
            end else if (op <= 5 && !lastWasRead) begin
                ifc.BUS_ADDR = BASE + 8'($urandom_range(3));
                ifc.BUS_WE = 1'b1; busDrvEn = 1'b1; busDrvVal = 8'($urandom_range(255));
            end
            ofs = ifc.BUS_ADDR - BASE;
            lastWasRead = !ifc.BUS_WE && (ofs <= 8'd2);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
